// File: rtl/tpram_stream_fifo.sv
// ---------------------------------------------------------------------------
// tpram_stream_fifo
//   Streaming FIFO controller around one std_tpram64x288 two-port RAM.
//   The write stream (valid/ready) is turned into active-low RAM write strobes.
//   Reads are issued ahead into a 2-entry skid buffer. This hides the RAM's
//   1-cycle registered read latency, so the output stream can move one beat
//   per cycle.
//
//   Handshake rule on both streams: a beat transfers in every cycle where
//   valid and ready are both 1 at the rising clock edge. While valid=1 and
//   ready=0, the sender holds valid and data stable.
//
// Ports
//   clk, rst_n           single clock (also the RAM clock), async active-low reset
//   flush                synchronous clear of all contents, highest priority
//   s_valid/s_ready/s_data   write stream in
//   m_valid/m_ready/m_data   read stream out (m_data = skid head)
//   ram_wceb/ram_waddr/ram_wdata   RAM write port (WCEB active low)
//   ram_rceb/ram_raddr/ram_rdata   RAM read port (RCEB active low,
//                                  RDATA valid the cycle after RCEB=0)
//   level                words held: RAM + in-flight read + skid (0..DEPTH+2)
// ---------------------------------------------------------------------------
module tpram_stream_fifo #(
    parameter int DW    = 288,
    parameter int AW    = 6,
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          ram_wceb,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_rceb,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata,
    output logic [AW+1:0] level
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   ram_cnt_q, ram_cnt_d;
    logic          rd_inflight_q, rd_inflight_d;
    logic [1:0]    skid_cnt_q, skid_cnt_d;
    logic [DW-1:0] skid0_q, skid0_d;   // head entry
    logic [DW-1:0] skid1_q, skid1_d;
    logic [AW+1:0] level_q, level_d;

    logic          wr;
    logic          rd;
    logic          pop;
    logic [1:0]    cap_idx;

    assign s_ready = (ram_cnt_q != DEPTH_C) & ~flush;
    assign m_valid = (skid_cnt_q != 2'd0);
    assign m_data  = skid0_q;
    assign pop     = m_valid & m_ready;

    // RAM strobes are gated with rst_n so that the RAM sees no access while
    // reset is held, even though s_ready reads 1 during reset.
    assign wr = s_valid & s_ready & rst_n;

    // Issue a read only when the skid buffer is sure to have room for the
    // word when it returns next cycle. Count the entry leaving this cycle.
    assign rd = (ram_cnt_q != '0)
              & ((3'(skid_cnt_q) + 3'(rd_inflight_q)) < (3'd2 + 3'(pop)))
              & ~flush & rst_n;

    assign ram_wceb  = ~wr;
    assign ram_waddr = wptr_q;
    assign ram_wdata = s_data;
    assign ram_rceb  = ~rd;
    assign ram_raddr = rptr_q;
    assign level     = level_q;

    always_comb begin
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        ram_cnt_d     = ram_cnt_q;
        rd_inflight_d = rd_inflight_q;
        skid_cnt_d    = skid_cnt_q;
        skid0_d       = skid0_q;
        skid1_d       = skid1_q;
        cap_idx       = 2'd0;

        if (flush) begin
            // Drop everything, including a read whose data returns this cycle.
            wptr_d        = '0;
            rptr_d        = '0;
            ram_cnt_d     = '0;
            rd_inflight_d = 1'b0;
            skid_cnt_d    = 2'd0;
        end else begin
            // DEPTH == 2**AW, so the pointers wrap through natural overflow.
            wptr_d        = wptr_q + AW'(wr);
            rptr_d        = rptr_q + AW'(rd);
            ram_cnt_d     = ram_cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
            rd_inflight_d = rd;

            if (pop) begin
                skid0_d = skid1_q;
            end
            // The returning word goes in right behind the entries that remain
            // after this cycle's pop.
            if (rd_inflight_q) begin
                cap_idx = skid_cnt_q - 2'(pop);
                if (cap_idx == 2'd0) begin
                    skid0_d = ram_rdata;
                end else begin
                    skid1_d = ram_rdata;
                end
            end
            skid_cnt_d = skid_cnt_q + 2'(rd_inflight_q) - 2'(pop);
        end

        level_d = (AW+2)'(ram_cnt_d) + (AW+2)'(rd_inflight_d) + (AW+2)'(skid_cnt_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            ram_cnt_q     <= '0;
            rd_inflight_q <= 1'b0;
            skid_cnt_q    <= 2'd0;
            skid0_q       <= '0;
            skid1_q       <= '0;
            level_q       <= '0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            ram_cnt_q     <= ram_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            skid_cnt_q    <= skid_cnt_d;
            skid0_q       <= skid0_d;
            skid1_q       <= skid1_d;
            level_q       <= level_d;
        end
    end

endmodule

// File: tb/tb_tpram_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_tpram_stream_fifo
//   Directed and random stimulus for tpram_stream_fifo. A behavioural
//   two-port RAM is attached to the RAM ports. The reference model is an
//   ordered queue of accepted words. Each pop must return the queue head, and
//   level must equal the queue size after every edge.
// ---------------------------------------------------------------------------
module tb_tpram_stream_fifo;

    localparam int DW    = 288;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          flush;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid, m_ready;
    logic [DW-1:0] m_data;
    logic          ram_wceb, ram_rceb;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic [AW+1:0] level;

    tpram_stream_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .ram_wceb  (ram_wceb),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_rceb  (ram_rceb),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .level     (level)
    );

    // Behavioural std_tpram64x288: registered read, RDATA held between reads.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (!ram_wceb) mem[ram_waddr] <= ram_wdata;
        if (!ram_rceb) ram_rdata <= mem[ram_raddr];
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  wr_total = 0;   // words accepted before the current cycle
    int  rd_total = 0;   // reads issued before the current cycle
    bit  did_pop, did_wr;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int k = 0; k < DW/32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    // One clock cycle. Inputs are set before the call (posedge+1). Handshakes
    // are sampled at the negedge and the model is updated there. Level is
    // checked 1 time unit after the posedge.
    task automatic cycle();
        logic [DW-1:0] e;
        @(negedge clk);
        did_pop = m_valid && m_ready;
        did_wr  = s_valid && s_ready;
        if (!ram_rceb) begin
            chk("rd_only_committed_words", DW'(rd_total < wr_total), DW'(1));
            rd_total++;
        end
        if (!s_ready) chk("no_wstrobe_when_not_ready", DW'(ram_wceb), DW'(1));
        if (did_pop) begin
            if (exp_q.size() == 0) begin
                chk("pop_when_model_empty", DW'(m_valid), DW'(0));
            end else begin
                e = exp_q.pop_front();
                chk("m_data", m_data, e);
            end
        end
        if (did_wr) begin
            exp_q.push_back(s_data);
            wr_total++;
        end
        if (flush) begin
            chk("flush_s_ready", DW'(s_ready), DW'(0));
            chk("flush_wceb", DW'(ram_wceb), DW'(1));
            chk("flush_rceb", DW'(ram_rceb), DW'(1));
            exp_q.delete();
            wr_total = 0;
            rd_total = 0;
        end
        @(posedge clk);
        #1;
        chk("level", DW'(level), DW'(exp_q.size()));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int next, first, last, pops, acc;

        rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", DW'(s_ready), DW'(1));
        chk("rst_m_valid", DW'(m_valid), DW'(0));
        chk("rst_wceb", DW'(ram_wceb), DW'(1));
        chk("rst_rceb", DW'(ram_rceb), DW'(1));
        chk("rst_level", DW'(level), DW'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word latency: accept at t, m_valid at t+3.
        s_data = {36{8'hA5}}; s_valid = 1'b1;
        cycle();
        s_valid = 1'b0;
        chk("lat_accept", DW'(did_wr), DW'(1));
        chk("lat_t1_m_valid", DW'(m_valid), DW'(0));
        cycle();
        chk("lat_t2_m_valid", DW'(m_valid), DW'(0));
        cycle();
        chk("lat_t3_m_valid", DW'(m_valid), DW'(1));
        chk("lat_t3_m_data", m_data, {36{8'hA5}});
        m_ready = 1'b1;
        cycle();
        chk("lat_pop", DW'(did_pop), DW'(1));
        m_ready = 1'b0;

        // Stream 200 incrementing words, m_ready held high.
        next = 0; first = -1; last = -1; pops = 0;
        m_ready = 1'b1;
        for (int c = 0; c < 260; c++) begin
            s_valid = (next < 200);
            s_data  = DW'(next);
            cycle();
            if (did_wr) next++;
            if (did_pop) begin
                if (first < 0) first = c;
                last = c;
                pops++;
            end
        end
        s_valid = 1'b0;
        chk("stream_accepts", DW'(next), DW'(200));
        chk("stream_pops", DW'(pops), DW'(200));
        chk("stream_no_bubbles", DW'(last - first), DW'(199));

        // Fill to capacity with the output blocked.
        m_ready = 1'b0; acc = 0;
        for (int c = 0; c < 70; c++) begin
            s_valid = 1'b1;
            s_data  = DW'(acc);
            cycle();
            if (did_wr) acc++;
        end
        s_valid = 1'b0;
        chk("full_accepts", DW'(acc), DW'(66));
        chk("full_level", DW'(level), DW'(66));
        chk("full_s_ready", DW'(s_ready), DW'(0));
        m_ready = 1'b1;
        for (int c = 0; c < 80; c++) cycle();
        chk("full_drained_m_valid", DW'(m_valid), DW'(0));
        chk("full_drained_level", DW'(level), DW'(0));

        // Random traffic, 50% valid / 50% ready.
        for (int c = 0; c < 10000; c++) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            s_data  = rand_word();
            cycle();
            if (level > 8'd66) chk("level_range", DW'(level), DW'(66));
        end
        s_valid = 1'b0; m_ready = 1'b1;
        for (int c = 0; c < 80; c++) cycle();
        chk("rand_drained_m_valid", DW'(m_valid), DW'(0));

        // Flush with 5 words buffered and a read in flight.
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            s_valid = 1'b1; s_data = rand_word();
            cycle();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        cycle();                        // pop one; this frees a slot, so a read issues
        m_ready = 1'b0;
        chk("pre_flush_m_valid", DW'(m_valid), DW'(1));
        flush = 1'b1; s_valid = 1'b1; s_data = rand_word();
        cycle();
        flush = 1'b0; s_valid = 1'b0;
        chk("post_flush_m_valid", DW'(m_valid), DW'(0));
        cycle();
        chk("post_flush_idle_m_valid", DW'(m_valid), DW'(0));
        s_valid = 1'b1; s_data = rand_word();
        cycle();
        s_valid = 1'b0; m_ready = 1'b1; pops = 0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (did_pop) pops++;
        end
        chk("post_flush_pops", DW'(pops), DW'(1));

        // Asynchronous reset in mid-stream, away from any clock edge.
        for (int c = 0; c < 20; c++) begin
            s_valid = 1'b1; s_data = rand_word();
            cycle();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", DW'(m_valid), DW'(0));
        chk("arst_rceb", DW'(ram_rceb), DW'(1));
        chk("arst_wceb", DW'(ram_wceb), DW'(1));
        chk("arst_level", DW'(level), DW'(0));
        exp_q.delete(); wr_total = 0; rd_total = 0;
        s_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        next = 0; pops = 0;
        for (int c = 0; c < 30; c++) begin
            s_valid = (next < 10);
            s_data  = DW'(next + 500);
            cycle();
            if (did_wr) next++;
            if (did_pop) pops++;
        end
        s_valid = 1'b0;
        chk("arst_after_pops", DW'(pops), DW'(10));
        chk("arst_after_m_valid", DW'(m_valid), DW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
